// File: rtl/decode_queue_pkg.sv
// Payload types shared by fetch, the decode queue and dispatch.
package decode_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  uop_class;
    logic [7:0]  op;
    logic        pred_taken;
    logic [31:0] pred_target;
  } decoded_bundle_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side push handshake, dual-wide dispatch view, flush and status of the decode queue.
interface decode_queue_if #(
  parameter int unsigned DEPTH = 8
);
  import decode_queue_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  decoded_bundle_t  in_bundle;
  logic             flush;
  logic             out_valid0;
  decoded_bundle_t  out_bundle0;
  logic             out_valid1;
  decoded_bundle_t  out_bundle1;
  logic [1:0]       out_pop;
  logic [CNT_W-1:0] count;
  logic             pop_err;

  // master: fetch/dispatch/redirect side; slave: the queue itself
  modport master (
    output in_valid, in_bundle, flush, out_pop,
    input  in_ready, out_valid0, out_bundle0, out_valid1, out_bundle1, count, pop_err
  );

  modport slave (
    input  in_valid, in_bundle, flush, out_pop,
    output in_ready, out_valid0, out_bundle0, out_valid1, out_bundle1, count, pop_err
  );

endinterface

// File: rtl/decode_queue.sv
// Circular buffer between fetch and a dual-wide dispatch stage, with single-cycle flush.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst,
  decode_queue_if.slave q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  decoded_bundle_t  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             err, err_next;

  logic             push;
  logic [1:0]       pop_req;
  logic [1:0]       eff_pop;
  logic             illegal_pop;

  // Ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
  assign q.in_ready    = (cnt != CNT_W'(DEPTH));
  assign q.out_valid0  = (cnt >= CNT_W'(1));
  assign q.out_valid1  = (cnt >= CNT_W'(2));
  assign q.out_bundle0 = mem[rd_ptr];
  assign q.out_bundle1 = mem[rd_ptr + PTR_W'(1)];
  assign q.count       = cnt;
  assign q.pop_err     = err;

  // Pop request is capped at the two visible slots, then at what is actually present.
  always_comb begin
    push        = 1'b0;
    pop_req     = q.out_pop;
    eff_pop     = 2'd0;
    illegal_pop = 1'b0;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    cnt_next    = cnt;
    err_next    = err;

    push = q.in_valid && q.in_ready && !q.flush;
    if (q.out_pop == 2'd3) begin
      pop_req = 2'd2;
    end
    eff_pop = (CNT_W'(pop_req) > cnt) ? 2'(cnt) : pop_req;
    illegal_pop = (q.out_pop == 2'd3) || (CNT_W'(q.out_pop) > cnt);

    if (illegal_pop) begin
      err_next = 1'b1;
    end

    if (q.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      cnt_next    = '0;
    end else begin
      wr_ptr_next = wr_ptr + PTR_W'(push);
      rd_ptr_next = rd_ptr + PTR_W'(eff_pop);
      cnt_next    = cnt + CNT_W'(push) - CNT_W'(eff_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      cnt    <= cnt_next;
      err    <= err_next;
    end
  end

  // Storage is deliberately not reset; valids gate its visibility.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= q.in_bundle;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: vector table, directed corner sequences, random vs queue model.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH)) bus ();
  decode_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));

  int tests = 0;
  int fails = 0;

  decoded_bundle_t mq[$];
  logic            merr = 1'b0;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [1:0]  pop;
    int          cnt;
    logic        rdy;
    logic [31:0] pc0;
    logic        v1;
    logic [31:0] pc1;
  } vec_t;

  vec_t vecs[$];

  function automatic decoded_bundle_t mk(input logic [31:0] pc);
    decoded_bundle_t b;
    b.pc          = pc;
    b.uop_class   = pc[5:2];
    b.op          = pc[7:0] ^ 8'h5a;
    b.pred_taken  = pc[2];
    b.pred_target = pc + 32'h100;
    return b;
  endfunction

  function automatic decoded_bundle_t rand_bundle();
    decoded_bundle_t b;
    b.pc          = $urandom;
    b.uop_class   = 4'($urandom);
    b.op          = 8'($urandom);
    b.pred_taken  = 1'($urandom);
    b.pred_target = $urandom;
    return b;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic fl, input logic [1:0] pop);
    bus.in_valid  = iv;
    bus.in_bundle = mk(pc);
    bus.flush     = fl;
    bus.out_pop   = pop;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a plain queue updated from the inputs seen before the edge.
  task automatic model_edge();
    int   sz;
    int   req;
    logic acc;
    sz  = mq.size();
    acc = bus.in_valid && (sz < int'(DEPTH)) && !bus.flush;
    if (bus.out_pop == 2'd3 || int'(bus.out_pop) > sz) merr = 1'b1;
    if (rst) begin
      mq.delete();
      merr = 1'b0;
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      req = (bus.out_pop == 2'd3) ? 2 : int'(bus.out_pop);
      if (req > sz) req = sz;
      repeat (req) void'(mq.pop_front());
      if (acc) mq.push_back(bus.in_bundle);
    end
  endtask

  task automatic model_check();
    int sz;
    sz = mq.size();
    check("m_count", 128'(bus.count), 128'(sz));
    check("m_ready", 128'(bus.in_ready), 128'(sz < int'(DEPTH)));
    check("m_valid0", 128'(bus.out_valid0), 128'(sz >= 1));
    check("m_valid1", 128'(bus.out_valid1), 128'(sz >= 2));
    check("m_pop_err", 128'(bus.pop_err), 128'(merr));
    if (sz >= 1) check("m_bundle0", 128'(bus.out_bundle0), 128'(mq[0]));
    if (sz >= 2) check("m_bundle1", 128'(bus.out_bundle1), 128'(mq[1]));
  endtask

  initial begin
    // fill 0x00..0x1C, then rejected 9th push, then dual drain with wrap
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 32'(4 * i), 2'd0, i + 1, (i < 7), 32'h00, (i >= 1), 32'h04});
    vecs.push_back('{1'b1, 32'h20, 2'd0, 8, 1'b0, 32'h00, 1'b1, 32'h04});
    vecs.push_back('{1'b1, 32'h20, 2'd2, 6, 1'b1, 32'h08, 1'b1, 32'h0C});
    vecs.push_back('{1'b1, 32'h20, 2'd2, 5, 1'b1, 32'h10, 1'b1, 32'h14});
    vecs.push_back('{1'b1, 32'h24, 2'd2, 4, 1'b1, 32'h18, 1'b1, 32'h1C});
    vecs.push_back('{1'b1, 32'h28, 2'd2, 3, 1'b1, 32'h20, 1'b1, 32'h24});
    vecs.push_back('{1'b1, 32'h2C, 2'd0, 4, 1'b1, 32'h20, 1'b1, 32'h24});

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    step();
    step();
    rst = 1'b0;
    check("rst_count", 128'(bus.count), 128'(0));
    check("rst_ready", 128'(bus.in_ready), 128'(1));
    check("rst_valid0", 128'(bus.out_valid0), 128'(0));
    check("rst_valid1", 128'(bus.out_valid1), 128'(0));
    check("rst_pop_err", 128'(bus.pop_err), 128'(0));

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].pc, 1'b0, vecs[i].pop);
      step();
      check($sformatf("vec%0d_count", i), 128'(bus.count), 128'(vecs[i].cnt));
      check($sformatf("vec%0d_ready", i), 128'(bus.in_ready), 128'(vecs[i].rdy));
      check($sformatf("vec%0d_valid0", i), 128'(bus.out_valid0), 128'(1));
      check($sformatf("vec%0d_pc0", i), 128'(bus.out_bundle0.pc), 128'(vecs[i].pc0));
      check($sformatf("vec%0d_valid1", i), 128'(bus.out_valid1), 128'(vecs[i].v1));
      if (vecs[i].v1) check($sformatf("vec%0d_pc1", i), 128'(bus.out_bundle1.pc), 128'(vecs[i].pc1));
    end

    // flush beats a simultaneous push and pop
    drive(1'b1, 32'h30, 1'b0, 2'd0);
    step();
    check("pre_flush_count", 128'(bus.count), 128'(5));
    drive(1'b1, 32'h40, 1'b1, 2'd1);
    step();
    check("flush_count", 128'(bus.count), 128'(0));
    check("flush_valid0", 128'(bus.out_valid0), 128'(0));
    check("flush_valid1", 128'(bus.out_valid1), 128'(0));
    check("flush_ready", 128'(bus.in_ready), 128'(1));
    drive(1'b1, 32'h40, 1'b0, 2'd0);
    step();
    check("refill_count", 128'(bus.count), 128'(1));
    check("refill_bundle0", 128'(bus.out_bundle0), 128'(mk(32'h40)));
    check("single_valid0", 128'(bus.out_valid0), 128'(1));
    check("single_valid1", 128'(bus.out_valid1), 128'(0));

    // push and pop with one entry keeps count at 1
    drive(1'b1, 32'h44, 1'b0, 2'd1);
    step();
    check("pushpop_count", 128'(bus.count), 128'(1));
    check("pushpop_pc0", 128'(bus.out_bundle0.pc), 128'(32'h44));

    // over-pop removes only what exists and latches the error
    drive(1'b0, 32'h0, 1'b0, 2'd2);
    step();
    check("overpop_count", 128'(bus.count), 128'(0));
    check("overpop_err", 128'(bus.pop_err), 128'(1));
    drive(1'b0, 32'h0, 1'b1, 2'd0);
    step();
    check("err_after_flush", 128'(bus.pop_err), 128'(1));

    // reset mid-operation with fetch still valid
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(32'h50 + 4 * i), 1'b0, 2'd0);
      step();
    end
    check("prerst_count", 128'(bus.count), 128'(6));
    drive(1'b1, 32'h68, 1'b0, 2'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_count", 128'(bus.count), 128'(0));
    check("midrst_ready", 128'(bus.in_ready), 128'(1));
    check("midrst_valid0", 128'(bus.out_valid0), 128'(0));
    check("midrst_valid1", 128'(bus.out_valid1), 128'(0));
    check("midrst_err", 128'(bus.pop_err), 128'(0));
    drive(1'b1, 32'h70, 1'b0, 2'd0);
    step();
    check("postrst_pc0", 128'(bus.out_bundle0.pc), 128'(32'h70));
    check("postrst_count", 128'(bus.count), 128'(1));

    // pop code 3 is illegal and retires at most two
    drive(1'b1, 32'h74, 1'b0, 2'd0);
    step();
    drive(1'b1, 32'h78, 1'b0, 2'd0);
    step();
    drive(1'b0, 32'h0, 1'b0, 2'd3);
    step();
    check("pop3_count", 128'(bus.count), 128'(1));
    check("pop3_pc0", 128'(bus.out_bundle0.pc), 128'(32'h78));
    check("pop3_err", 128'(bus.pop_err), 128'(1));

    // random traffic against the queue model
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    model_edge();
    step();
    rst = 1'b0;
    model_check();
    for (int n = 0; n < 600; n++) begin
      int pop;
      pop = int'($urandom_range(0, 2));
      if (pop > mq.size()) pop = mq.size();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_bundle = rand_bundle();
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.out_pop   = 2'(pop);
      rst           = ($urandom_range(0, 99) == 0);
      model_edge();
      step();
      rst = 1'b0;
      model_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
